// File: rtl/input_cond_pkg.sv
// Shared constants for the push-button / slide-switch input conditioner.
package input_cond_pkg;

  localparam int NUM_KEYS  = 6;

  localparam int KEY_UP    = 0;
  localparam int KEY_DOWN  = 1;
  localparam int KEY_LEFT  = 2;
  localparam int KEY_RIGHT = 3;
  localparam int KEY_SET   = 4;
  localparam int KEY_CONT  = 5;

  // Defaults sized for a 50 MHz system clock.
  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_PULSE_CYCLES    = 2500000;
  localparam int DEF_REPEAT_DELAY    = 25000000;
  localparam int DEF_REPEAT_PERIOD   = 5000000;

  typedef logic [NUM_KEYS-1:0] key_vec_t;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// Board-side signals of the input conditioner: raw buttons/switch in, PIO-facing levels out.
interface input_conditioner_if;
  import input_cond_pkg::*;

  key_vec_t   key_n;
  logic       sw_mode;
  logic [1:0] up_down;
  logic [1:0] left_right;
  logic       set_value;
  logic       continue0;
  logic       auto_manual;

  modport master (
    output key_n, sw_mode,
    input  up_down, left_right, set_value, continue0, auto_manual
  );

  modport slave (
    input  key_n, sw_mode,
    output up_down, left_right, set_value, continue0, auto_manual
  );

endinterface

// File: rtl/key_debounce.sv
// Two-flop synchronizer, debounce window and press (stable 0->1) detect for one raw input.
module key_debounce
  import input_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic press
);

  localparam logic             IDLE_LEVEL = ACTIVE_LOW;
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_reg;
  logic             sync2_reg;
  logic             stable_reg;
  logic             press_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             sampled;

  // Inversion happens after the synchronizer so both flops see the raw pin.
  assign sampled = sync2_reg ^ ACTIVE_LOW;

  // Synchronizer resets to the idle pin level so an unpressed key never looks pressed after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg  <= IDLE_LEVEL;
      sync2_reg  <= IDLE_LEVEL;
      stable_reg <= 1'b0;
      press_reg  <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
      press_reg <= 1'b0;
      if (sampled == stable_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg >= LAST_COUNT) begin
        stable_reg <= sampled;
        press_reg  <= sampled;
        cnt_reg    <= '0;
      end else begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign stable = stable_reg;
  assign press  = press_reg;

endmodule

// File: rtl/input_conditioner.sv
// Debounces six buttons and a mode switch, stretches presses for PIO polling, applies the
// opposing-pair lockout; define INPUT_COND_AUTOREPEAT_EN to add auto-repeat on the arrow keys.
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int PULSE_CYCLES    = DEF_PULSE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic                clk,
  input  logic                reset,
  input_conditioner_if.slave  pins
);

  localparam int NUM_INPUTS = NUM_KEYS + 1;
  localparam int MAX_PARAM  = max_of(max_of(DEBOUNCE_CYCLES, PULSE_CYCLES),
                                     max_of(REPEAT_DELAY, REPEAT_PERIOD));
  localparam int CNT_W      = $clog2(MAX_PARAM) + 1;
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES);

  logic [NUM_INPUTS-1:0] raw;
  logic                  stable [NUM_INPUTS];
  logic                  press  [NUM_INPUTS];
  logic                  pair_ud;
  logic                  pair_lr;
  key_vec_t              suppress;
  key_vec_t              repeat_fire;
  key_vec_t              active;

  // The mode switch rides along as the last input; only the keys are active-low.
  assign raw = {pins.sw_mode, pins.key_n};

  generate
    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_in
      key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W),
        .ACTIVE_LOW      ((gi < NUM_KEYS) ? 1'b1 : 1'b0)
      ) u_deb (
        .clk    (clk),
        .reset  (reset),
        .raw    (raw[gi]),
        .stable (stable[gi]),
        .press  (press[gi])
      );
    end
  endgenerate

  assign pair_ud = stable[KEY_UP]   & stable[KEY_DOWN];
  assign pair_lr = stable[KEY_LEFT] & stable[KEY_RIGHT];

  generate
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_sup
      if (gi == KEY_UP || gi == KEY_DOWN) begin : g_ud
        assign suppress[gi] = pair_ud;
      end else if (gi == KEY_LEFT || gi == KEY_RIGHT) begin : g_lr
        assign suppress[gi] = pair_lr;
      end else begin : g_none
        assign suppress[gi] = 1'b0;
      end
    end
  endgenerate

`ifdef INPUT_COND_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] DELAY_THR  = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] PERIOD_THR = CNT_W'(REPEAT_PERIOD);

  generate
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_rpt
      if (gi <= KEY_RIGHT) begin : g_arrow
        logic [CNT_W-1:0] rpt_cnt_reg;
        logic             rpt_armed_reg;
        logic [CNT_W-1:0] thr;

        // Counter restarts at 1 after each repeat so the next one lands exactly one period later.
        assign thr             = rpt_armed_reg ? PERIOD_THR : DELAY_THR;
        assign repeat_fire[gi] = stable[gi] && !suppress[gi] && (rpt_cnt_reg == thr);

        always_ff @(posedge clk) begin
          if (reset || !stable[gi] || suppress[gi]) begin
            rpt_cnt_reg   <= '0;
            rpt_armed_reg <= 1'b0;
          end else if (repeat_fire[gi]) begin
            rpt_cnt_reg   <= CNT_W'(1);
            rpt_armed_reg <= 1'b1;
          end else if (rpt_cnt_reg < thr) begin
            rpt_cnt_reg <= rpt_cnt_reg + CNT_W'(1);
          end
        end
      end else begin : g_no_rpt
        assign repeat_fire[gi] = 1'b0;
      end
    end
  endgenerate
`else
  assign repeat_fire = '0;
`endif

  // Pair lockout wins over a simultaneous load so a two-key press never leaks a pulse.
  generate
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_str
      logic [CNT_W-1:0] stretch_reg;

      always_ff @(posedge clk) begin
        if (reset || suppress[gi]) begin
          stretch_reg <= '0;
        end else if (press[gi] || repeat_fire[gi]) begin
          stretch_reg <= PULSE_LOAD;
        end else if (stretch_reg != '0) begin
          stretch_reg <= stretch_reg - CNT_W'(1);
        end
      end

      assign active[gi] = (stretch_reg != '0) && !suppress[gi];
    end
  endgenerate

  assign pins.up_down     = {active[KEY_UP], active[KEY_DOWN]};
  assign pins.left_right  = {active[KEY_LEFT], active[KEY_RIGHT]};
  assign pins.set_value   = active[KEY_SET];
  assign pins.continue0   = active[KEY_CONT];
  assign pins.auto_manual = stable[NUM_KEYS];

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench: stimulus queues expected output pulses, a monitor measures and compares them.
module tb_input_conditioner;

  localparam int DEB = 4;
  localparam int PUL = 8;
  localparam int RD  = 20;
  localparam int RP  = 6;

  localparam int SIG_DOWN  = 0;
  localparam int SIG_UP    = 1;
  localparam int SIG_RIGHT = 2;
  localparam int SIG_LEFT  = 3;
  localparam int SIG_SET   = 4;
  localparam int SIG_CONT  = 5;
  localparam int SIG_AUTO  = 6;

  typedef struct {
    int sig;
    int start;
    int len;
  } pulse_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;
  int   p;
  logic [6:0] obs;
  pulse_t exp_q[$];

  input_conditioner_if pins();

  input_conditioner #(
    .DEBOUNCE_CYCLES (DEB),
    .PULSE_CYCLES    (PUL),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .pins  (pins)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign obs = {pins.auto_manual, pins.continue0, pins.set_value, pins.left_right, pins.up_down};

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  task automatic expect_pulse(input int sig, input int start, input int len);
    pulse_t e;
    e.sig = sig;
    e.start = start;
    e.len = len;
    exp_q.push_back(e);
  endtask

  task automatic press_key(input int idx, input int hold);
    pins.key_n[idx] = 1'b0;
    tick(hold);
    pins.key_n[idx] = 1'b1;
  endtask

  // Monitor: one transaction per completed output pulse.
  initial begin
    int rise_cyc [7];
    logic [6:0] prev;
    pulse_t e;
    int len;
    prev = '0;
    foreach (rise_cyc[i]) rise_cyc[i] = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        for (int b = 0; b < 7; b++) begin
          if (obs[b] && !prev[b]) begin
            rise_cyc[b] = cyc;
          end else if (!obs[b] && prev[b]) begin
            len = cyc - rise_cyc[b];
            checks++;
            if (exp_q.size() == 0) begin
              failures++;
              $display("FAIL pulse_unexpected sig=%0d start=%0d len=%0d required=none", b, rise_cyc[b], len);
            end else begin
              e = exp_q.pop_front();
              if (e.sig != b || e.start != rise_cyc[b] || e.len != len) begin
                failures++;
                $display("FAIL pulse_match actual sig=%0d start=%0d len=%0d required sig=%0d start=%0d len=%0d",
                         b, rise_cyc[b], len, e.sig, e.start, e.len);
              end else begin
                $display("pulse sig=%0d start=%0d len=%0d ok", b, rise_cyc[b], len);
              end
            end
          end
        end
        prev = obs;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    pins.key_n = '1;
    pins.sw_mode = 1'b0;
    tick(3);
    check("reset_outputs", 32'(obs), 32'd0);
    reset = 1'b0;
    mon_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check("idle_outputs", 32'(obs), 32'd0);
    end
    tick(5);

    // Clean set press: rises 6 cycles after first sample, 8 cycles long, nothing on release.
    p = cyc + 1;
    expect_pulse(SIG_SET, p + 6, PUL);
    press_key(4, 12);
    tick(30);

    // Continue bounces: low 2, high 1, then low; behaves like a clean press 3 cycles later.
    p = cyc + 1;
    expect_pulse(SIG_CONT, p + 9, PUL);
    pins.key_n[5] = 1'b0;
    tick(2);
    pins.key_n[5] = 1'b1;
    tick(1);
    pins.key_n[5] = 1'b0;
    tick(15);
    pins.key_n[5] = 1'b1;
    tick(30);

    // Single up and single down presses check bit mapping.
    p = cyc + 1;
    expect_pulse(SIG_UP, p + 6, PUL);
    press_key(0, 12);
    tick(30);
    p = cyc + 1;
    expect_pulse(SIG_DOWN, p + 6, PUL);
    press_key(1, 12);
    tick(30);

    // Up and down together: lockout keeps up_down at zero throughout.
    pins.key_n[1:0] = 2'b00;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      check("pair_up_down", 32'(pins.up_down), 32'd0);
    end
    pins.key_n[1:0] = 2'b11;
    tick(30);

    // Left re-pressed while stretching: second event reloads on the last active cycle.
    p = cyc + 1;
    expect_pulse(SIG_LEFT, p + 6, 2 * PUL);
    pins.key_n[2] = 1'b0;
    tick(4);
    pins.key_n[2] = 1'b1;
    tick(4);
    pins.key_n[2] = 1'b0;
    tick(12);
    pins.key_n[2] = 1'b1;
    tick(30);

    // Reset 3 cycles into a stretch; key held through reset gives a fresh press afterwards.
    p = cyc + 1;
    expect_pulse(SIG_SET, p + 6, 3);
    expect_pulse(SIG_SET, p + 16, PUL);
    pins.key_n[4] = 1'b0;
    tick(9);
    reset = 1'b1;
    tick(1);
    check("reset_mid_stretch", 32'(obs), 32'd0);
    reset = 1'b0;
    tick(11);
    pins.key_n[4] = 1'b1;
    tick(30);

    // Mode switch glitch of 2 cycles is ignored.
    pins.sw_mode = 1'b1;
    tick(2);
    pins.sw_mode = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check("sw_glitch", 32'(pins.auto_manual), 32'd0);
    end
    tick(5);

    // Mode switch held 20 cycles: level follows after debounce, same length.
    p = cyc + 1;
    expect_pulse(SIG_AUTO, p + 5, 20);
    pins.sw_mode = 1'b1;
    tick(20);
    pins.sw_mode = 1'b0;
    tick(30);

    // Right held 50 cycles: auto-repeat events at +20,+26..+44 merge into one long stretch.
    p = cyc + 1;
    expect_pulse(SIG_RIGHT, p + 6, PUL);
`ifdef INPUT_COND_AUTOREPEAT_EN
    expect_pulse(SIG_RIGHT, p + 26, 32);
`endif
    press_key(3, 50);
    tick(40);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("final_outputs", 32'(obs), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000; number of cycles a synchronized input must hold a new value before it is accepted (10 ms at 50 MHz).
REQ-002 Parameter PULSE_CYCLES, default 2500000; stretched press-pulse length, so software polling of the PIO cannot miss a press.
REQ-003 Parameter REPEAT_DELAY, default 25000000; hold time before auto-repeat starts.
REQ-004 Parameter REPEAT_PERIOD, default 5000000; auto-repeat interval.
REQ-005 Port clk, input, 1; single system clock. All logic runs on its rising edge.
REQ-006 Port reset, input, 1; synchronous, active-high reset.
REQ-007 Port key_n, input, 6; raw active-low push buttons, indexed [0]=up, [1]=down, [2]=left, [3]=right, [4]=set, [5]=continue.
REQ-008 Port sw_mode, input, 1; raw auto/manual slide switch.
REQ-009 Port up_down, output, 2; [1]=up press, [0]=down press; feeds the up/down PIO.
REQ-010 Port left_right, output, 2; [1]=left press, [0]=right press; feeds the left/right PIO.
REQ-011 Port set_value, output, 1; stretched set press.
REQ-012 Port continue0, output, 1; stretched continue press.
REQ-013 Port auto_manual, output, 1; debounced switch level.

Function
REQ-014 Each raw input shall pass through a 2-flop synchronizer; key inputs shall be inverted after synchronization, so 1 = pressed.
REQ-015 Each synchronized input shall have a debounce counter:
  - The counter increments while the synchronized value differs from the stable value, and clears to 0 when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1, the stable value takes the new value and the counter clears.
REQ-016 Any bounce back to the stable value within the window shall restart the window; a glitch shorter than DEBOUNCE_CYCLES shall never change the stable value.
REQ-017 Press event = a stable 0->1 transition. There shall be no event on release.
REQ-018 Latency: a clean press first sampled in cycle N shall assert its output in cycle N+DEBOUNCE_CYCLES+2 (2 synchronizer cycles plus the debounce window).
REQ-019 Pulse stretcher per key: an event loads PULSE_CYCLES, the counter decrements each cycle, and the output is high while the counter is nonzero (exactly PULSE_CYCLES cycles).
REQ-020 A new event while a stretch is active shall reload the counter (retrigger); the output shall not drop in between.
REQ-021 Opposing-pair rule:
  - If up and down are both stable-pressed, both up_down bits shall be forced to 0 and any pending stretch cleared.
  - The same rule applies to left/right.
REQ-022 auto_manual shall equal the debounced stable value of sw_mode, with no stretching.
REQ-023 All counters shall saturate; none shall wrap. Counter width = $clog2(max parameter)+1.

Reset
REQ-024 reset shall clear synchronizers, stable values, debounce counters, stretch counters and repeat counters.
REQ-025 After reset, all outputs shall be 0.
REQ-026 A key held through reset deassertion shall produce a press event after the debounce window.
REQ-027 Reset asserted mid-stretch shall drop the output on the next edge.

Configuration
REQ-028 Macro INPUT_COND_AUTOREPEAT_EN.
REQ-029 When defined, each of up/down/left/right shall behave as follows while stable-pressed:
  - A repeat counter runs.
  - After REPEAT_DELAY cycles, a synthetic event fires, then another every REPEAT_PERIOD cycles.
  - The counter clears on release.
  - The opposing-pair rule suppresses repeats.
REQ-030 When undefined, no repeat logic shall be present; only one event per press.
REQ-031 set and continue shall never auto-repeat in either build.

Structure
REQ-032 Package input_cond_pkg shall hold:
  - key index constants (KEY_UP..KEY_CONT);
  - NUM_KEYS=6;
  - the default parameter constants.
REQ-033 Sub-module key_debounce (synchronizer + debounce + edge detect, parameterized by DEBOUNCE_CYCLES) shall be instantiated 7 times.
REQ-034 Stretching, pair rule and repeat logic shall reside in input_conditioner.

Verification (DEBOUNCE_CYCLES=4, PULSE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=6)
REQ-035 Clean press of key_n[4] from cycle 10 -> set_value rises cycle 16 and is high exactly 8 cycles; nothing on release.
REQ-036 key_n[5] bounces low 2 cycles, high 1, then low steady -> continue0 gives exactly one 8-cycle pulse.
REQ-037 key_n[0] and key_n[1] pressed together and held -> up_down stays 2'b00 throughout.
REQ-038 Second press of key_n[2] while its stretch is active -> left_right[1] stays high, ending 8 cycles after the second event.
REQ-039 Reset pulsed 3 cycles into a stretch -> all outputs 0 next cycle; sw_mode toggle of 2 cycles -> auto_manual unchanged.
REQ-040 With INPUT_COND_AUTOREPEAT_EN, hold key_n[3] for 50 cycles -> left_right[0] events at 0, 20, 26, 32, 38 and 44 cycles after the first event; without the macro -> a single event.
